// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch with PC register, IF/ID register and field decode.
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          IMEM_AW  = 6
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    output logic [31:0]        pc,
    output logic [31:0]        instr_d,
    output logic [31:0]        pc_plus4_d,
    output logic               valid_d,
    output logic [5:0]         op,
    output logic [5:0]         funct,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [15:0]        imm,
    output logic               misalign_err,
    output logic [31:0]        fetch_count
);
    logic [31:0] pcNext;

    assign pcNext    = pc + 32'd4;
    assign imem_addr = pc[IMEM_AW+1:2];

    // A redirect flushes IF/ID even under stall, leaving exactly one bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= PC_RESET;
            instr_d      <= '0;
            pc_plus4_d   <= '0;
            valid_d      <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= '0;
        end else if (branch_taken) begin
            pc           <= {branch_target[31:2], 2'b00};
            instr_d      <= '0;
            pc_plus4_d   <= '0;
            valid_d      <= 1'b0;
            misalign_err <= misalign_err | (|branch_target[1:0]);
        end else if (!stall) begin
            pc          <= pcNext;
            instr_d     <= imem_rdata;
            pc_plus4_d  <= pcNext;
            valid_d     <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

    assign op    = instr_d[31:26];
    assign rs    = instr_d[25:21];
    assign rt    = instr_d[20:16];
    assign rd    = instr_d[15:11];
    assign imm   = instr_d[15:0];
    assign funct = instr_d[5:0];
endmodule
